// File: rtl/bcd_countdown_2digit.sv
// Two-digit BCD down counter (99..00) with prescaled count steps.
// A prescaler produces a one-cycle tick every TICK_DIV clocks while running;
// each tick decrements the BCD value, and reaching 00 raises Done for a cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | holding a loaded/finished value, waiting for Start
// RUN     | prescaler counting, digits decrement on every tick
// PAUSED  | prescaler and digits frozen while Pause is high
// FINISH  | count reached 00; Done is high for this single cycle
module bcd_countdown_2digit #(
    parameter int TICK_DIV = 25000000,
    parameter int PS_W     = 25
) (
    input  logic       Clk,
    input  logic       RST,
    input  logic       Load,
    input  logic       Start,
    input  logic       Pause,
    input  logic [3:0] Preset_Tens,
    input  logic [3:0] Preset_Ones,
    output logic [3:0] Tens,
    output logic [3:0] Ones,
    output logic       Tick_O,
    output logic       Running,
    output logic       Done,
    output logic       Zero
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_tens;
    logic [3:0]      r_ones;
    logic [3:0]      w_tens_nxt;
    logic [3:0]      w_ones_nxt;
    logic [PS_W-1:0] r_ps;
    logic [PS_W-1:0] w_ps_nxt;
    logic            r_running;

    logic            w_tick;
    logic            w_zero;
    logic            w_last_step;
    logic [3:0]      w_preset_tens;
    logic [3:0]      w_preset_ones;

    // Presets above 9 are not valid BCD, so they saturate to 9.
    assign w_preset_tens = (Preset_Tens > 4'd9) ? 4'd9 : Preset_Tens;
    assign w_preset_ones = (Preset_Ones > 4'd9) ? 4'd9 : Preset_Ones;

    assign w_tick      = (r_state == S_RUN) && (r_ps == PS_LAST);
    assign w_zero      = (r_tens == 4'd0) && (r_ones == 4'd0);
    // The step from 01 is the one that lands on 00.
    assign w_last_step = (r_tens == 4'd0) && (r_ones == 4'd1);

    // Next-state, next-digit and next-prescaler decode; Load overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_tens_nxt  = r_tens;
        w_ones_nxt  = r_ones;
        w_ps_nxt    = r_ps;

        if (Load) begin
            w_state_nxt = S_IDLE;
            w_tens_nxt  = w_preset_tens;
            w_ones_nxt  = w_preset_ones;
            w_ps_nxt    = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Pause outranks Start, so a held Pause keeps us idle.
                    if (Start && !Pause) begin
                        w_ps_nxt    = '0;
                        w_state_nxt = w_zero ? S_FINISH : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_tick) begin
                        w_ps_nxt = '0;
                        if (r_ones == 4'd0) begin
                            w_ones_nxt = 4'd9;
                            w_tens_nxt = r_tens - 4'd1;
                        end else begin
                            w_ones_nxt = r_ones - 4'd1;
                        end
                        // Reaching 00 ends the count even if Pause is also high.
                        if (w_last_step) begin
                            w_state_nxt = S_FINISH;
                        end else if (Pause) begin
                            w_state_nxt = S_PAUSED;
                        end
                    end else begin
                        w_ps_nxt = r_ps + 1'b1;
                        if (Pause) begin
                            w_state_nxt = S_PAUSED;
                        end
                    end
                end
                S_PAUSED: begin
                    if (!Pause) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_FINISH: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, digits, prescaler and the registered Running flag.
    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_tens    <= 4'd0;
            r_ones    <= 4'd0;
            r_ps      <= '0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tens    <= w_tens_nxt;
            r_ones    <= w_ones_nxt;
            r_ps      <= w_ps_nxt;
            r_running <= (w_state_nxt == S_RUN);
        end
    end

    // Outputs are decoded from registers only, so they move on clock edges.
    assign Tens    = r_tens;
    assign Ones    = r_ones;
    assign Tick_O  = w_tick;
    assign Running = r_running;
    assign Done    = (r_state == S_FINISH);
    assign Zero    = w_zero;

endmodule

// File: tb/tb_bcd_countdown_2digit.sv
// Bench for bcd_countdown_2digit: vector table, directed corner sequences and
// randomized stimulus against a decimal-valued reference model.
module tb_bcd_countdown_2digit;

    localparam int D = 4;

    logic       Clk = 1'b0;
    logic       RST = 1'b0;
    logic       Load = 1'b0;
    logic       Start = 1'b0;
    logic       Pause = 1'b0;
    logic [3:0] PT = 4'd0;
    logic [3:0] PO = 4'd0;
    logic [3:0] Tens;
    logic [3:0] Ones;
    logic       Tick_O;
    logic       Running;
    logic       Done;
    logic       Zero;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: value kept as a plain integer 0..99.
    // m_mode: 0 idle, 1 run, 2 paused, 3 finish; m_cyc counts cycles within a step.
    int m_mode = 0;
    int m_val  = 0;
    int m_cyc  = 0;

    typedef struct {
        logic       ld;
        logic       st;
        logic       pa;
        logic [3:0] pt;
        logic [3:0] po;
        int         et;
        int         eo;
        logic       er;
        logic       ed;
        logic       ez;
    } vec_t;

    vec_t vecs [13];

    bcd_countdown_2digit #(.TICK_DIV(D), .PS_W(3)) dut (
        .Clk         (Clk),
        .RST         (RST),
        .Load        (Load),
        .Start       (Start),
        .Pause       (Pause),
        .Preset_Tens (PT),
        .Preset_Ones (PO),
        .Tens        (Tens),
        .Ones        (Ones),
        .Tick_O      (Tick_O),
        .Running     (Running),
        .Done        (Done),
        .Zero        (Zero)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_mode = 0;
        m_val  = 0;
        m_cyc  = 0;
    endfunction

    function automatic void model_step();
        bit step_now;
        int t;
        int o;
        step_now = (m_mode == 1) && (m_cyc == D - 1);
        t = (PT > 4'd9) ? 9 : int'(PT);
        o = (PO > 4'd9) ? 9 : int'(PO);
        if (Load) begin
            m_val  = t * 10 + o;
            m_cyc  = 0;
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (Start && !Pause) begin
                       m_cyc  = 0;
                       m_mode = (m_val == 0) ? 3 : 1;
                   end
                1: begin
                       if (step_now) begin
                           m_val = m_val - 1;
                           m_cyc = 0;
                           if (m_val == 0) m_mode = 3;
                           else if (Pause) m_mode = 2;
                       end else begin
                           m_cyc = m_cyc + 1;
                           if (Pause) m_mode = 2;
                       end
                   end
                2: if (!Pause) m_mode = 1;
                default: m_mode = 0;
            endcase
        end
    endfunction

    task automatic check(input string name, input integer act, input integer exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("tens",    Tens,    m_val / 10);
        check("ones",    Ones,    m_val % 10);
        check("running", Running, (m_mode == 1) ? 1 : 0);
        check("done",    Done,    (m_mode == 3) ? 1 : 0);
        check("zero",    Zero,    (m_val == 0) ? 1 : 0);
        check("tick",    Tick_O,  (m_mode == 1 && m_cyc == D - 1) ? 1 : 0);
    endtask

    task automatic cyc();
        model_step();
        @(posedge Clk);
        #1;
        check_model();
    endtask

    task automatic set_in(input logic ld, input logic st, input logic pa,
                          input logic [3:0] t, input logic [3:0] o);
        Load  = ld;
        Start = st;
        Pause = pa;
        PT    = t;
        PO    = o;
    endtask

    initial begin
        int ticks;
        int last_tick;
        int done_at;
        int done_cnt;
        int n;
        bit prev_tick;
        bit found;

        // Reset state, checked while RST is still low.
        #1;
        check("rst_tens",    Tens,    0);
        check("rst_ones",    Ones,    0);
        check("rst_running", Running, 0);
        check("rst_done",    Done,    0);
        check("rst_zero",    Zero,    1);
        check("rst_tick",    Tick_O,  0);
        #11;
        RST = 1'b1;
        model_reset();
        cyc();

        // Vector table: {Load, Start, Pause, PT, PO} -> {Tens, Ones, Running, Done, Zero}.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd1,  4'd2,  1, 2, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'hC,  4'd3,  9, 3, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'hF,  4'hF,  9, 9, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  0, 0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  0, 0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'd0,  4'd5,  0, 5, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  0, 5, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  0, 5, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 5, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 5, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  0, 4, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 4'd3,  4'd0,  3, 0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].ld, vecs[i].st, vecs[i].pa, vecs[i].pt, vecs[i].po);
            model_step();
            @(posedge Clk);
            #1;
            check($sformatf("vec%0d_tens", i),    Tens,    vecs[i].et);
            check($sformatf("vec%0d_ones", i),    Ones,    vecs[i].eo);
            check($sformatf("vec%0d_running", i), Running, vecs[i].er);
            check($sformatf("vec%0d_done", i),    Done,    vecs[i].ed);
            check($sformatf("vec%0d_zero", i),    Zero,    vecs[i].ez);
        end
        set_in(0, 0, 0, 0, 0);
        cyc();

        // Full countdown from 12: 12 steps, Done exactly one cycle after the last tick.
        set_in(1, 0, 0, 4'd1, 4'd2); cyc();
        set_in(0, 1, 0, 4'd0, 4'd0); cyc();
        set_in(0, 0, 0, 4'd0, 4'd0);
        ticks = 0; last_tick = -10; done_at = -1; done_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            cyc();
            if (Tick_O) begin ticks++; last_tick = c; end
            if (Done) begin done_cnt++; if (done_at < 0) done_at = c; end
            if (done_at >= 0 && c > done_at + 1) break;
        end
        check("cd_ticks",     ticks,    12);
        check("cd_done_cnt",  done_cnt, 1);
        check("cd_done_lat",  done_at - last_tick, 1);
        check("cd_end_zero",  Zero,     1);
        check("cd_end_run",   Running,  0);

        // Borrow from 20: first step 19, eleventh step 09.
        set_in(1, 0, 0, 4'd2, 4'd0); cyc();
        set_in(0, 1, 0, 4'd0, 4'd0); cyc();
        set_in(0, 0, 0, 4'd0, 4'd0);
        n = 0; prev_tick = 0; found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            cyc();
            if (prev_tick) begin
                n++;
                if (n == 1)  begin check("borrow_t1", Tens, 1); check("borrow_o1", Ones, 9); end
                if (n == 11) begin check("borrow_t11", Tens, 0); check("borrow_o11", Ones, 9); found = 1; end
            end
            prev_tick = Tick_O;
        end
        check("borrow_reached", found, 1);

        // Pause after first step (04), hold 20 cycles, then resume from the held prescaler.
        set_in(1, 0, 0, 4'd0, 4'd5); cyc();
        set_in(0, 1, 0, 4'd0, 4'd0); cyc();
        set_in(0, 0, 0, 4'd0, 4'd0);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            cyc();
            if (Tens == 4'd0 && Ones == 4'd4) found = 1;
        end
        check("pause_first_step", found, 1);
        Pause = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cyc();
            check("pause_ones", Ones, 4);
            check("pause_tick", Tick_O, 0);
            check("pause_run",  Running, 0);
        end
        Pause = 1'b0;
        n = 0; found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            cyc();
            n++;
            if (Ones == 4'd3) found = 1;
        end
        // One edge back to RUN, then the D-1 prescaler steps left after the held one.
        check("resume_latency", n, 1 + (D - 1));

        // Load with 0xF,0x7 on a tick cycle: value 97, idle, no decrement, no Done.
        set_in(1, 0, 0, 4'd1, 4'd5); cyc();
        set_in(0, 1, 0, 4'd0, 4'd0); cyc();
        set_in(0, 0, 0, 4'd0, 4'd0);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (Tick_O) found = 1;
            else cyc();
        end
        check("ldtick_found", found, 1);
        set_in(1, 0, 0, 4'hF, 4'd7); cyc();
        check("ldtick_tens", Tens, 9);
        check("ldtick_ones", Ones, 7);
        check("ldtick_run",  Running, 0);
        check("ldtick_done", Done, 0);
        set_in(0, 0, 0, 4'd0, 4'd0); cyc();
        check("ldtick_done2", Done, 0);

        // Async reset between edges at 07 clears outputs immediately.
        set_in(1, 0, 0, 4'd0, 4'd9); cyc();
        set_in(0, 1, 0, 4'd0, 4'd0); cyc();
        set_in(0, 0, 0, 4'd0, 4'd0);
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            cyc();
            if (Tens == 4'd0 && Ones == 4'd7) found = 1;
        end
        check("arst_reach07", found, 1);
        #2;
        RST = 1'b0;
        #1;
        check("arst_tens",    Tens,    0);
        check("arst_ones",    Ones,    0);
        check("arst_running", Running, 0);
        check("arst_done",    Done,    0);
        check("arst_zero",    Zero,    1);
        model_reset();
        @(posedge Clk);
        #3;
        RST = 1'b1;
        @(posedge Clk);
        #1;
        check_model();
        for (int c = 0; c < 10; c++) cyc();
        set_in(1, 0, 0, 4'd0, 4'd3); cyc();
        set_in(0, 1, 0, 4'd0, 4'd0); cyc();
        set_in(0, 0, 0, 4'd0, 4'd0);
        for (int c = 0; c < 16; c++) cyc();

        // Randomized stimulus against the reference model.
        for (int c = 0; c < 3000; c++) begin
            set_in(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
